nanov_fetch: RTL and testbench

NANOV_FETCH -- requirements
Module: nanov_fetch

---
 rtl/nanov_pkg.sv | 27 ++
 rtl/nanov_fetch_buffer.sv | 84 ++++++++
 rtl/nanov_fetch.sv | 166 ++++++++++++++++
 tb/tb_nanov_fetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_pkg.sv
`default_nettype none
// ==================================================================
// nanov_pkg: shared SPI read constants, FSM state type, byte helper.
// Rev 1.0
// ==================================================================
package nanov_pkg;

  localparam logic [7:0] SPI_READ_CMD  = 8'h03;
  localparam int         SPI_CMD_BITS  = 8;
  localparam int         SPI_ADDR_BITS = 24;
  localparam int         SPI_WORD_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } fetch_state_t;

  // Serial stream arrives byte0 first; instruction words are little-endian.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nanov_fetch_buffer.sv
`default_nettype none
// ==================================================================
// nanov_fetch_buffer: two-entry instr/next_instr buffer and pc.
// Rev 1.0
// ==================================================================
module nanov_fetch_buffer
  import nanov_pkg::*;
#(
  parameter int                   ADDR_BITS  = 24,
  parameter logic [ADDR_BITS-1:0] RESET_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_flush,
  input  logic [ADDR_BITS-1:0]     i_flush_pc,
  input  logic                     i_take,
  input  logic                     i_wr,
  input  logic [SPI_WORD_BITS-1:0] i_wr_data,
  output logic [SPI_WORD_BITS-1:0] o_instr,
  output logic                     o_instr_valid,
  output logic [SPI_WORD_BITS-1:0] o_next_instr,
  output logic                     o_next_valid,
  output logic [ADDR_BITS-1:0]     o_pc,
  output logic                     o_full
);

  logic [SPI_WORD_BITS-1:0] r_instr;
  logic [SPI_WORD_BITS-1:0] r_next;
  logic                     r_iv;
  logic                     r_nv;
  logic [ADDR_BITS-1:0]     r_pc;

  logic                     w_take;
  logic                     w_iv_after;
  logic                     w_nv_after;
  logic [SPI_WORD_BITS-1:0] w_instr_after;

  // Slot occupancy as it stands once this cycle's take has been applied.
  always_comb begin
    w_take        = i_take & r_iv;
    w_iv_after    = w_take ? r_nv : r_iv;
    w_nv_after    = w_take ? 1'b0 : r_nv;
    w_instr_after = w_take ? r_next : r_instr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_instr <= '0;
      r_next  <= '0;
      r_iv    <= 1'b0;
      r_nv    <= 1'b0;
      r_pc    <= RESET_ADDR;
    end else if (i_flush) begin
      r_iv <= 1'b0;
      r_nv <= 1'b0;
      r_pc <= i_flush_pc;
    end else begin
      r_iv    <= w_iv_after;
      r_nv    <= w_nv_after;
      r_instr <= w_instr_after;
      if (w_take) begin
        r_pc <= r_pc + ADDR_BITS'(4);
      end
      if (i_wr) begin
        if (!w_iv_after) begin
          r_instr <= i_wr_data;
          r_iv    <= 1'b1;
        end else if (!w_nv_after) begin
          r_next <= i_wr_data;
          r_nv   <= 1'b1;
        end
      end
    end
  end

  assign o_instr       = r_instr;
  assign o_instr_valid = r_iv;
  assign o_next_instr  = r_next;
  assign o_next_valid  = r_nv;
  assign o_pc          = r_pc;
  assign o_full        = r_iv & r_nv;

endmodule
`default_nettype wire

// File: rtl/nanov_fetch.sv
`default_nettype none
// ==================================================================
// nanov_fetch: SPI flash (cmd 0x03) sequential instruction fetcher.
// Rev 1.0
// ==================================================================
module nanov_fetch
  import nanov_pkg::*;
#(
  parameter int                   ADDR_BITS  = 24,
  parameter logic [ADDR_BITS-1:0] RESET_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 spi_cs_n,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  input  logic                 branch,
  input  logic [ADDR_BITS-1:0] branch_addr,
  input  logic                 instr_take,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [31:0]          next_instr,
  output logic                 next_valid,
  output logic [ADDR_BITS-1:0] pc
);

  fetch_state_t               r_state;
  fetch_state_t               w_state_nxt;
  logic                       r_cs_n;
  logic                       r_sclk;
  logic                       r_mosi;
  logic [4:0]                 r_bit_cnt;
  logic                       r_gap_cnt;
  logic [30:0]                r_tx;
  logic [30:0]                r_rx;
  logic [ADDR_BITS-1:0]       r_fetch_addr;

  logic [SPI_ADDR_BITS-1:0]   w_addr24;
  logic [ADDR_BITS-1:0]       w_branch_pc;
  logic                       w_active;
  logic                       w_bit_end;
  logic                       w_last_cmd;
  logic                       w_last_addr;
  logic                       w_last_word;
  logic                       w_start;
  logic                       w_full;
  logic                       w_stall;
  logic                       w_word_done;
  logic [SPI_WORD_BITS-1:0]   w_word;

  generate
    if (ADDR_BITS >= SPI_ADDR_BITS) begin : g_addr_trunc
      assign w_addr24 = r_fetch_addr[SPI_ADDR_BITS-1:0];
    end else begin : g_addr_ext
      assign w_addr24 = {{(SPI_ADDR_BITS-ADDR_BITS){1'b0}}, r_fetch_addr};
    end
  endgenerate

  assign w_branch_pc = branch_addr & ~(ADDR_BITS'(3));
  assign w_active    = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_bit_end   = w_active & r_sclk;
  assign w_last_cmd  = (r_bit_cnt == 5'(SPI_CMD_BITS - 1));
  assign w_last_addr = (r_bit_cnt == 5'(SPI_ADDR_BITS - 1));
  assign w_last_word = (r_bit_cnt == 5'(SPI_WORD_BITS - 1));
  assign w_start     = (r_state == ST_IDLE) || ((r_state == ST_GAP) && r_gap_cnt);
  // Hold the last bit of a word in its low phase while no slot can accept it.
  assign w_stall     = (r_state == ST_DATA) & w_last_word & ~r_sclk & w_full;
  assign w_word_done = (r_state == ST_DATA) & w_bit_end & w_last_word & ~branch;
  assign w_word      = byte_swap32({r_rx, spi_miso});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_CMD;
      ST_CMD:  if (w_bit_end && w_last_cmd)  w_state_nxt = ST_ADDR;
      ST_ADDR: if (w_bit_end && w_last_addr) w_state_nxt = ST_DATA;
      ST_DATA: w_state_nxt = ST_DATA;
      ST_GAP:  if (r_gap_cnt) w_state_nxt = ST_CMD;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (branch) begin
      w_state_nxt = ST_GAP;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cs_n       <= 1'b1;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_fetch_addr <= RESET_ADDR;
    end else if (branch) begin
      r_cs_n       <= 1'b1;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= 1'b0;
      r_fetch_addr <= w_branch_pc;
    end else if (w_start) begin
      r_cs_n    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= SPI_READ_CMD[7];
      r_tx      <= {SPI_READ_CMD[6:0], w_addr24};
      r_bit_cnt <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap_cnt <= 1'b1;
    end else if (w_active) begin
      if (!r_sclk) begin
        if (!w_stall) begin
          r_sclk <= 1'b1;
        end
      end else begin
        // End of the high phase: sample miso, present the next mosi bit.
        r_sclk <= 1'b0;
        r_mosi <= r_tx[30];
        r_tx   <= {r_tx[29:0], 1'b0};
        if (r_state == ST_DATA) begin
          r_rx <= {r_rx[29:0], spi_miso};
        end
        if (((r_state == ST_CMD) && w_last_cmd) || ((r_state == ST_ADDR) && w_last_addr)) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
    end
  end

  nanov_fetch_buffer #(
    .ADDR_BITS  (ADDR_BITS),
    .RESET_ADDR (RESET_ADDR)
  ) u_buffer (
    .clk           (clk),
    .rstn          (rstn),
    .i_flush       (branch),
    .i_flush_pc    (w_branch_pc),
    .i_take        (instr_take),
    .i_wr          (w_word_done),
    .i_wr_data     (w_word),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_next_instr  (next_instr),
    .o_next_valid  (next_valid),
    .o_pc          (pc),
    .o_full        (w_full)
  );

  assign spi_cs_n = r_cs_n;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_nanov_fetch.sv
`default_nettype none
// ==================================================================
// tb_nanov_fetch: flash model, directed vectors and random fetch stream.
// Rev 1.0
// ==================================================================
module tb_nanov_fetch;

  localparam int          AB    = 24;
  localparam logic [23:0] RST_A = 24'h000000;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        spi_cs_n, spi_clk, spi_mosi;
  logic        spi_miso = 1'b0;
  logic        branch = 1'b0;
  logic [23:0] branch_addr = '0;
  logic        instr_take = 1'b0;
  logic [31:0] instr, next_instr;
  logic        instr_valid, next_valid;
  logic [23:0] pc;

  nanov_fetch #(.ADDR_BITS(AB), .RESET_ADDR(RST_A)) dut (
    .clk(clk), .rstn(rstn), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .branch(branch),
    .branch_addr(branch_addr), .instr_take(instr_take), .instr(instr),
    .instr_valid(instr_valid), .next_instr(next_instr),
    .next_valid(next_valid), .pc(pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%08h required=%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash contents: word 0 is 0x00000013, the rest a deterministic hash.
  function automatic logic [31:0] mem_word(input logic [23:0] a);
    if (a == 24'h0) return 32'h0000_0013;
    return ({8'h00, a} * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [31:0] w;
    w = mem_word({a[23:2], 2'b00}) >> {a[1:0], 3'b000};
    return w[7:0];
  endfunction

  // Serial flash: 32 header bits in on rising spi_clk, then data bits out.
  int          fl_n = 0;
  int          fl_txn = 0;
  int          fl_d;
  logic [31:0] fl_hdr = '0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0;
  logic [7:0]  fl_b;

  always @(negedge spi_cs_n) fl_n = 0;

  always @(posedge spi_clk) begin
    if (!spi_cs_n) begin
      if (fl_n < 32) begin
        fl_hdr = {fl_hdr[30:0], spi_mosi};
        if (fl_n == 31) begin
          fl_cmd  = fl_hdr[31:24];
          fl_addr = fl_hdr[23:0];
          fl_txn++;
        end
      end else begin
        fl_d     = fl_n - 32;
        fl_b     = mem_byte(fl_addr + 24'(fl_d / 8));
        spi_miso = fl_b[7 - (fl_d % 8)];
      end
      fl_n++;
    end
  end

  task automatic wait_csn_fall(output int c);
    bit ok;
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!spi_cs_n) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    chk("csn_fall_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(output int c);
    bit ok;
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    chk("instr_valid_seen", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [23:0] exp_pc;
  } bvec_t;

  bvec_t tbl [4];

  initial begin
    int c0, c1, c2, t0, hi, ntake;
    bit ok;
    logic [23:0] m_pc;

    tbl[0] = '{addr: 24'h000103, exp_pc: 24'h000100};
    tbl[1] = '{addr: 24'hFFFFFF, exp_pc: 24'hFFFFFC};
    tbl[2] = '{addr: 24'h12345A, exp_pc: 24'h123458};
    tbl[3] = '{addr: 24'h000000, exp_pc: 24'h000000};

    // Asynchronous reset state, checked before any clock edge.
    #2 rstn = 1'b0;
    #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_next", next_instr, 32'd0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_nv", 32'(next_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'(RST_A));

    // First fetch after release, then let the buffer fill and stall.
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    c2 = cyc;
    wait_csn_fall(c0);
    chk("idle_to_cmd_cycles", 32'(c0 - c2), 32'd1);
    wait_valid(c1);
    chk("first_valid_latency", 32'(c1 - c0), 32'd128);
    chk("first_cmd", 32'(fl_cmd), 32'h03);
    chk("first_addr", 32'(fl_addr), 32'(RST_A));
    chk("first_instr", instr, 32'h0000_0013);
    chk("first_pc", 32'(pc), 32'(RST_A));
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (next_valid) begin
        ok = 1'b1;
        c2 = cyc;
      end
    end
    chk("next_valid_latency", 32'(c2 - c0), 32'd192);
    chk("next_instr_w1", next_instr, mem_word(24'd4));
    while (cyc < c0 + 400) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (spi_clk) hi++;
    end
    chk("stall_sclk_high", 32'(hi), 32'd0);
    chk("stall_cs_n", 32'(spi_cs_n), 32'd0);
    chk("stall_instr_kept", instr, 32'h0000_0013);
    instr_take = 1'b1;
    @(negedge clk);
    instr_take = 1'b0;
    chk("take_instr", instr, mem_word(24'd4));
    chk("take_pc", 32'(pc), 32'd4);
    chk("take_nv_cleared", 32'(next_valid), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (next_valid) ok = 1'b1;
    end
    chk("stall_release_nv", 32'(ok), 32'd1);
    chk("stall_release_word8", next_instr, mem_word(24'd8));

    // Branch and take landing on the same edge as a word completion.
    branch = 1'b1;
    branch_addr = 24'h000040;
    @(negedge clk);
    branch = 1'b0;
    wait_csn_fall(c0);
    while (cyc < c0 + 191) @(negedge clk);
    chk("cc_iv_before", 32'(instr_valid), 32'd1);
    chk("cc_nv_before", 32'(next_valid), 32'd0);
    chk("cc_pc_before", 32'(pc), 32'h40);
    branch = 1'b1;
    branch_addr = 24'h000203;
    instr_take = 1'b1;
    @(negedge clk);
    branch = 1'b0;
    instr_take = 1'b0;
    chk("cc_iv", 32'(instr_valid), 32'd0);
    chk("cc_nv", 32'(next_valid), 32'd0);
    chk("cc_pc", 32'(pc), 32'h200);

    // Table of redirects issued during DATA.
    for (int k = 0; k < 4; k++) begin
      wait_valid(c1);
      branch = 1'b1;
      branch_addr = tbl[k].addr;
      @(negedge clk);
      branch = 1'b0;
      chk("br_iv", 32'(instr_valid), 32'd0);
      chk("br_nv", 32'(next_valid), 32'd0);
      chk("br_pc", 32'(pc), 32'(tbl[k].exp_pc));
      chk("br_gap_cs1", 32'(spi_cs_n), 32'd1);
      @(negedge clk);
      chk("br_gap_cs2", 32'(spi_cs_n), 32'd1);
      chk("br_gap_sclk", 32'(spi_clk), 32'd0);
      @(negedge clk);
      chk("br_cs_low", 32'(spi_cs_n), 32'd0);
      c0 = cyc;
      t0 = fl_txn;
      wait_valid(c1);
      chk("br_latency", 32'(c1 - c0), 32'd128);
      chk("br_txn", 32'(fl_txn), 32'(t0 + 1));
      chk("br_cmd", 32'(fl_cmd), 32'h03);
      chk("br_addr", 32'(fl_addr), 32'(tbl[k].exp_pc));
      chk("br_instr", instr, mem_word(tbl[k].exp_pc));
      chk("br_pc_hold", 32'(pc), 32'(tbl[k].exp_pc));
    end

    // Reset asserted while the address is being shifted out.
    branch = 1'b1;
    branch_addr = 24'h000300;
    @(negedge clk);
    branch = 1'b0;
    wait_csn_fall(c0);
    while (cyc < c0 + 30) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("mid_rst_sclk", 32'(spi_clk), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'(RST_A));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    t0 = fl_txn;
    wait_csn_fall(c0);
    wait_valid(c1);
    chk("rerst_latency", 32'(c1 - c0), 32'd128);
    chk("rerst_txn", 32'(fl_txn), 32'(t0 + 1));
    chk("rerst_addr", 32'(fl_addr), 32'(RST_A));
    chk("rerst_instr", instr, 32'h0000_0013);

    // Stream: take whenever valid, then random takes and redirects.
    m_pc  = RST_A;
    ntake = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      instr_take = 1'b0;
      branch     = 1'b0;
      if (i > 800 && $urandom_range(0, 299) == 0) begin
        branch      = 1'b1;
        branch_addr = 24'($urandom);
        m_pc        = branch_addr & 24'hFFFFFC;
      end else if (instr_valid && (i < 800 || $urandom_range(0, 1) == 1)) begin
        chk("seq_instr", instr, mem_word(m_pc));
        chk("seq_pc", 32'(pc), 32'(m_pc));
        if (next_valid) chk("seq_next", next_instr, mem_word(m_pc + 24'd4));
        instr_take = 1'b1;
        m_pc       = m_pc + 24'd4;
        ntake++;
      end
    end
    @(negedge clk);
    instr_take = 1'b0;
    branch     = 1'b0;
    chk("seq_progress", 32'(ntake >= 20), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
